// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: divides clk down to MDC and serialises one
// read or write frame per accepted host command, all in the clk domain.
module mdio_master #(
  parameter int unsigned HALF_DIV = 10,
  parameter int unsigned PRE_LEN  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  input  logic        cmd_no_pre,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_z,
  input  logic        mdio_in
);

  localparam int unsigned DIV_W = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned FRM_W = 32;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_STOP, S_ADDR, S_TA, S_DATA, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic             mdc_q, mdc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] sh_q, sh_d;
  logic             write_q, write_d;
  logic [15:0]      rx_q, rx_d;
  logic             ta_err_q, ta_err_d;
  logic             mdio_out_q, mdio_out_d;
  logic             mdio_z_q, mdio_z_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic             accept;
  logic             in_frame;
  logic             tc;
  logic             rise;
  logic             fall;
  logic             last_bit;
  logic             step;
  logic [FRM_W-1:0] cmd_frame;

  assign accept   = cmd_valid && cmd_ready_q;
  assign in_frame = (state_q == S_PRE) || (state_q == S_STOP) || (state_q == S_ADDR) ||
                    (state_q == S_TA)  || (state_q == S_DATA);
  assign tc       = in_frame && (div_q == DIV_TC);
  assign rise     = tc && !mdc_q;
  assign fall     = tc && mdc_q;
  assign step     = fall && last_bit;

  // ST, OP, PHYAD, REGAD, TA, DATA; bits after ADDR are unused on reads
  assign cmd_frame = {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy, cmd_reg, 2'b10,
                      (cmd_write ? cmd_wdata : 16'h0000)};

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      S_PRE:   last_bit = (cnt_q == CNT_W'(PRE_LEN - 1));
      S_STOP:  last_bit = (cnt_q == CNT_W'(3));
      S_ADDR:  last_bit = (cnt_q == CNT_W'(9));
      S_TA:    last_bit = (cnt_q == CNT_W'(1));
      S_DATA:  last_bit = (cnt_q == CNT_W'(15));
      default: last_bit = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = cmd_no_pre ? S_STOP : S_PRE;
      S_PRE:  if (step) state_d = S_STOP;
      S_STOP: if (step) state_d = S_ADDR;
      S_ADDR: if (step) state_d = S_TA;
      S_TA:   if (step) state_d = S_DATA;
      S_DATA: if (step) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    div_d       = div_q;
    mdc_d       = mdc_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    write_d     = write_q;
    rx_d        = rx_q;
    ta_err_d    = ta_err_q;
    mdio_out_d  = mdio_out_q;
    mdio_z_d    = mdio_z_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cmd_ready_d = (state_d == S_IDLE);

    if ((state_q == S_IDLE) && accept) begin
      write_d  = cmd_write;
      div_d    = '0;
      mdc_d    = 1'b0;
      cnt_d    = '0;
      mdio_z_d = 1'b0;
      if (cmd_no_pre) begin
        mdio_out_d = cmd_frame[FRM_W-1];
        sh_d       = {cmd_frame[FRM_W-2:0], 1'b0};
      end else begin
        mdio_out_d = 1'b1;
        sh_d       = cmd_frame;
      end
    end

    if (in_frame) begin
      if (tc) begin
        div_d = '0;
        mdc_d = !mdc_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    // PHY-driven bits are captured as MDC rises
    if (rise) begin
      if ((state_q == S_TA) && (cnt_q == CNT_W'(1))) ta_err_d = mdio_in;
      if (state_q == S_DATA) rx_d = {rx_q[14:0], mdio_in};
    end

    // Host-driven bits advance as MDC falls
    if (fall) begin
      cnt_d = step ? '0 : cnt_q + CNT_W'(1);
      if ((state_q == S_DATA) && step) begin
        mdio_z_d    = 1'b1;
        mdio_out_d  = 1'b1;
        mdc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = write_q ? 1'b0 : ta_err_q;
        if (!write_q) rsp_rdata_d = rx_q;
      end else if ((state_q == S_PRE) && !step) begin
        mdio_out_d = 1'b1;
      end else begin
        mdio_out_d = sh_q[FRM_W-1];
        sh_d       = {sh_q[FRM_W-2:0], 1'b0};
        if ((state_q == S_ADDR) && step) mdio_z_d = !write_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      mdc_q       <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      write_q     <= 1'b0;
      rx_q        <= '0;
      ta_err_q    <= 1'b0;
      mdio_out_q  <= 1'b1;
      mdio_z_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      mdc_q       <= mdc_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      write_q     <= write_d;
      rx_q        <= rx_d;
      ta_err_q    <= ta_err_d;
      mdio_out_q  <= mdio_out_d;
      mdio_z_q    <= mdio_z_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = !cmd_ready_q;
  assign mdc       = mdc_q;
  assign mdio_out  = mdio_out_q;
  assign mdio_z    = mdio_z_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: MDC-edge monitor, clause-22 frame model and a simple PHY.
module tb_mdio_master;

  localparam int unsigned HD = 4;
  localparam int unsigned PL = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        cmd_no_pre;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_z;
  logic        mdio_in = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic mon_out[$];
  logic mon_z[$];
  logic exp_bit[$];
  logic exp_z[$];

  logic        phy_rd = 1'b0;
  logic        phy_present = 1'b0;
  logic [15:0] phy_data = 16'h0;
  int          phy_pre = 0;
  logic [15:0] exp_rdata = 16'h0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  mdio_master #(.HALF_DIV(HD), .PRE_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_no_pre(cmd_no_pre),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdio_out(mdio_out), .mdio_z(mdio_z), .mdio_in(mdio_in)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge mdc) begin
    mon_out.push_back(mdio_out);
    mon_z.push_back(mdio_z);
  end

  // PHY answers a read with TA bit 2 low, then data MSB first; otherwise MDIO floats high
  function automatic logic phy_bit(input int k);
    int idx;
    if (!phy_rd || !phy_present) return 1'b1;
    if (k == phy_pre + 15) return 1'b0;
    if (k >= phy_pre + 16 && k < phy_pre + 32) begin
      idx = phy_pre + 31 - k;
      return phy_data[4'(idx)];
    end
    return 1'b1;
  endfunction

  always @(negedge mdc) mdio_in = phy_bit(mon_out.size());

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic b, input logic z);
    exp_bit.push_back(b);
    exp_z.push_back(z);
  endtask

  task automatic build_expected(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                                input logic [15:0] wd, input logic np);
    exp_bit.delete();
    exp_z.delete();
    if (!np) for (int i = 0; i < int'(PL); i++) push_exp(1'b1, 1'b0);
    push_exp(1'b0, 1'b0);
    push_exp(1'b1, 1'b0);
    push_exp(!wr, 1'b0);
    push_exp(wr, 1'b0);
    for (int i = 4; i >= 0; i--) push_exp(pa[i], 1'b0);
    for (int i = 4; i >= 0; i--) push_exp(ra[i], 1'b0);
    if (wr) begin
      push_exp(1'b1, 1'b0);
      push_exp(1'b0, 1'b0);
      for (int i = 15; i >= 0; i--) push_exp(wd[i], 1'b0);
    end else begin
      for (int i = 0; i < 18; i++) push_exp(1'b0, 1'b1);
    end
  endtask

  task automatic do_frame(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, input logic np, input logic present,
                          input logic [15:0] pdata, input logic hold);
    int n, acc, lat, bad_out, bad_z, nb;
    phy_rd = !wr;
    phy_present = present;
    phy_data = pdata;
    phy_pre = np ? 0 : int'(PL);
    mon_out.delete();
    mon_z.delete();
    build_expected(wr, pa, ra, wd, np);
    cmd_write = wr; cmd_phy = pa; cmd_reg = ra; cmd_wdata = wd; cmd_no_pre = np;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check("accept_wait", 32'(cmd_ready), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    check("busy_after_accept", 32'({busy, cmd_ready}), 32'b10);
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
    lat = cyc - acc;
    check("latency", 32'(lat), 32'((phy_pre + 32) * 2 * int'(HD)));
    if (!wr) exp_rdata = present ? pdata : 16'hFFFF;
    exp_err = !wr && !present;
    check("rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check("err", 32'(rsp_err), 32'(exp_err));
    check("done_pins", 32'({mdc, mdio_z, mdio_out}), 32'b011);
    check("mdc_periods", 32'(mon_out.size()), 32'(exp_bit.size()));
    bad_out = 0;
    bad_z = 0;
    nb = (mon_out.size() < exp_bit.size()) ? mon_out.size() : exp_bit.size();
    for (int i = 0; i < nb; i++) begin
      if (mon_z[i] !== exp_z[i]) bad_z++;
      if (!exp_z[i] && (mon_out[i] !== exp_bit[i])) bad_out++;
    end
    check("stream_out", 32'(bad_out), 32'd0);
    check("stream_z", 32'(bad_z), 32'd0);
    @(negedge clk);
    check("post_done", 32'({rsp_valid, cmd_ready, mdc}), 32'b010);
  endtask

  initial begin
    int n;
    logic rsp_seen, mdc_seen;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phy = '0; cmd_reg = '0;
    cmd_wdata = '0; cmd_no_pre = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pins", 32'({mdc, mdio_z, mdio_out, rsp_valid, cmd_ready, busy}), 32'b011001);
    check("rst_rdata", 32'({rsp_err, rsp_rdata}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'({cmd_ready, mdc}), 32'b10);

    do_frame(1'b1, 5'd1, 5'd0, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_frame(1'b0, 5'd3, 5'd1, 16'h0000, 1'b0, 1'b1, 16'h786D, 1'b0);
    do_frame(1'b0, 5'd5, 5'd2, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    do_frame(1'b1, 5'd7, 5'd9, 16'hA5C3, 1'b1, 1'b0, 16'h0000, 1'b0);
    check("nopre_first", 32'({mon_out[0], mon_out[1]}), 32'b01);
    do_frame(1'b1, 5'd2, 5'd4, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1);
    do_frame(1'b0, 5'd2, 5'd4, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0);

    for (int i = 0; i < 6; i++) begin
      do_frame(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
    end

    // Reset in the middle of a read's data phase
    phy_rd = 1'b1; phy_present = 1'b1; phy_data = 16'h5A5A; phy_pre = int'(PL);
    mon_out.delete();
    mon_z.delete();
    cmd_write = 1'b0; cmd_phy = 5'd4; cmd_reg = 5'd6; cmd_no_pre = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (mon_out.size() < int'(PL) + 20 && n < 2000) begin @(negedge clk); n++; end
    check("reach_data", 32'(mon_out.size() >= int'(PL) + 20), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid", 32'({mdc, mdio_z, rsp_valid, cmd_ready}), 32'b0100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", 32'(cmd_ready), 32'd1);
    rsp_seen = 1'b0;
    mdc_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rsp_seen |= rsp_valid;
      mdc_seen |= mdc;
      @(negedge clk);
    end
    check("no_rsp_after_rst", 32'({rsp_seen, mdc_seen}), 32'b00);
    exp_rdata = 16'h0000;
    exp_err = 1'b0;
    check("rdata_after_rst", 32'({rsp_err, rsp_rdata}), 32'd0);
    do_frame(1'b0, 5'd9, 5'd17, 16'h0000, 1'b0, 1'b1, 16'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
